wb_sched: RTL and testbench

- Register-file write-port scheduler for the write-back stage of the vcpu1 pipeline.
- Arbitrates the single regfile write port between two requesters:
  - EX path: the value already chosen by the write-data selector for ADDU/ADDUI/MOV/MOVIL/MOVIH. It can be stalled.
  - Load-return path: LD data from memory, variable latency. It cannot be stalled.
- Holds a per-register pending-load scoreboard and an outstanding-load counter, and gives decode a hazard/stall indication.

---
 rtl/wb_sched_pkg.sv | 20 ++
 rtl/wb_skid_fifo.sv | 79 +++++++
 rtl/wb_sched.sv | 190 +++++++++++++++++++
 tb/tb_wb_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sched_pkg.sv
// Shared defaults and types for the write-back port scheduler.
package wb_sched_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int RA_W_DEF   = 5;
   localparam int MAX_LD_DEF = 4;
   localparam int SKID_D_DEF = 2;

   // Outstanding-load counter width (MAX_LD is limited to 1..15).
   localparam int LDC_W = 4;

   // Which requester owns the regfile write port this cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_MEM  = 2'd1,
      SRC_SKID = 2'd2,
      SRC_EX   = 2'd3
   } wsrc_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small synchronous FIFO of {rd, data} that holds EX results waiting for the
// write port.  Per-entry valid/rd vectors are exported for the hazard check.
module wb_skid_fifo #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5,
   parameter int DEPTH  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_push,
   input  logic [RA_W-1:0]                i_push_rd,
   input  logic [DATA_W-1:0]              i_push_data,
   input  logic                           i_pop,
   output logic [$clog2(DEPTH):0]         o_count,
   output logic [RA_W-1:0]                o_head_rd,
   output logic [DATA_W-1:0]              o_head_data,
   output logic [DEPTH-1:0]               o_vld,
   output logic [DEPTH-1:0][RA_W-1:0]     o_rd
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][RA_W-1:0]   r_rd;
   logic [DEPTH-1:0][DATA_W-1:0] r_data;
   logic [DEPTH-1:0]             r_vld;
   logic [PW-1:0]                r_wptr;
   logic [PW-1:0]                r_rptr;
   logic [CW-1:0]                r_cnt;

   // Pointer/valid bookkeeping; caller never pushes when full or pops when empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_vld  <= '0;
      end else begin
         if (i_pop) begin
            r_vld[r_rptr] <= 1'b0;
            r_rptr        <= r_rptr + 1'b1;
         end
         if (i_push) begin
            r_vld[r_wptr] <= 1'b1;
            r_wptr        <= r_wptr + 1'b1;
         end
      end
   end

   // Entry payload storage; contents are meaningless while the valid bit is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd   <= '0;
         r_data <= '0;
      end else if (i_push) begin
         r_rd[r_wptr]   <= i_push_rd;
         r_data[r_wptr] <= i_push_data;
      end
   end

   // Occupancy count; simultaneous push and pop cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_count     = r_cnt;
   assign o_head_rd   = r_rd[r_rptr];
   assign o_head_data = r_data[r_rptr];
   assign o_vld       = r_vld;
   assign o_rd        = r_rd;

endmodule

// File: rtl/wb_sched.sv
// Write-back scheduler: shares the single regfile write port between the
// never-stalled load-return path and the stallable EX path, tracks pending
// loads per register, and tells decode when it must stall.
module wb_sched
   import wb_sched_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RA_W   = RA_W_DEF,
   parameter int MAX_LD = MAX_LD_DEF,
   parameter int SKID_D = SKID_D_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [RA_W-1:0]   ex_rd,
   input  logic [DATA_W-1:0] ex_data,
   output logic              ex_ready,
   input  logic              ld_issue,
   input  logic [RA_W-1:0]   ld_issue_rd,
   output logic              ld_can_issue,
   input  logic              mem_rvalid,
   input  logic [RA_W-1:0]   mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rf_we,
   output logic [RA_W-1:0]   rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [RA_W-1:0]   dec_rs1,
   input  logic [RA_W-1:0]   dec_rs2,
   input  logic [RA_W-1:0]   dec_rd,
   output logic              hazard,
   output logic              err
);

   localparam int NREG = 1 << RA_W;
   localparam int CW   = $clog2(SKID_D) + 1;

   logic [LDC_W-1:0]  r_ld_cnt;
   logic [NREG-1:0]   r_sb;
   logic              r_err;
   logic              r_we;
   logic [RA_W-1:0]   r_waddr;
   logic [DATA_W-1:0] r_wdata;

   logic [CW-1:0]                 w_buf_cnt;
   logic [RA_W-1:0]               w_head_rd;
   logic [DATA_W-1:0]             w_head_data;
   logic [SKID_D-1:0]             w_ent_vld;
   logic [SKID_D-1:0][RA_W-1:0]   w_ent_rd;

   logic  w_ex_acc;
   logic  w_buf_empty;
   logic  w_ld_full;
   logic  w_ld_empty;
   logic  w_ld_ok;
   logic  w_rv_ok;
   logic  w_err_set;
   logic  w_push;
   logic  w_pop;
   wsrc_e w_src;
   logic  w_haz;

   assign w_buf_empty  = (w_buf_cnt == '0);
   assign ex_ready     = (w_buf_cnt < CW'(SKID_D));
   assign w_ex_acc     = ex_valid && ex_ready;

   assign w_ld_full    = (r_ld_cnt == LDC_W'(MAX_LD));
   assign w_ld_empty   = (r_ld_cnt == '0);
   assign ld_can_issue = (r_ld_cnt < LDC_W'(MAX_LD));

   // A load beyond the limit is dropped; a return with nothing outstanding is
   // dropped and not written.
   assign w_ld_ok = ld_issue && !w_ld_full;
   assign w_rv_ok = mem_rvalid && !w_ld_empty;

   assign w_err_set = (ld_issue && w_ld_full)
                   || (mem_rvalid && w_ld_empty)
                   || (w_rv_ok && !r_sb[mem_rd]);

   // Port arbitration: load return, then oldest buffered EX, then a direct EX
   // only when nothing is buffered so EX order is preserved.  A dropped
   // return still occupies the port for that cycle.
   always_comb begin
      w_src  = SRC_NONE;
      w_pop  = 1'b0;
      w_push = 1'b0;
      if (mem_rvalid) begin
         w_src = w_rv_ok ? SRC_MEM : SRC_NONE;
      end else if (!w_buf_empty) begin
         w_src = SRC_SKID;
         w_pop = 1'b1;
      end else if (w_ex_acc) begin
         w_src = SRC_EX;
      end
      w_push = w_ex_acc && (w_src != SRC_EX);
   end

   wb_skid_fifo #(
      .DATA_W (DATA_W),
      .RA_W   (RA_W),
      .DEPTH  (SKID_D)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_rd   (ex_rd),
      .i_push_data (ex_data),
      .i_pop       (w_pop),
      .o_count     (w_buf_cnt),
      .o_head_rd   (w_head_rd),
      .o_head_data (w_head_data),
      .o_vld       (w_ent_vld),
      .o_rd        (w_ent_rd)
   );

   // Registered write port; address/data hold between writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= (w_src != SRC_NONE);
         case (w_src)
            SRC_MEM: begin
               r_waddr <= mem_rd;
               r_wdata <= mem_rdata;
            end
            SRC_SKID: begin
               r_waddr <= w_head_rd;
               r_wdata <= w_head_data;
            end
            SRC_EX: begin
               r_waddr <= ex_rd;
               r_wdata <= ex_data;
            end
            default: begin
               r_waddr <= r_waddr;
               r_wdata <= r_wdata;
            end
         endcase
      end
   end

   // Outstanding-load count; issue and return together net to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ld_cnt <= '0;
      end else begin
         case ({w_ld_ok, w_rv_ok})
            2'b10:   r_ld_cnt <= r_ld_cnt + 1'b1;
            2'b01:   r_ld_cnt <= r_ld_cnt - 1'b1;
            default: r_ld_cnt <= r_ld_cnt;
         endcase
      end
   end

   // Pending-load scoreboard; the set is applied last so it wins over a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sb <= '0;
      end else begin
         if (mem_rvalid) r_sb[mem_rd] <= 1'b0;
         if (w_ld_ok)    r_sb[ld_issue_rd] <= 1'b1;
      end
   end

   // Sticky protocol-error flag.
   always_ff @(posedge clk) begin
      if (rst)            r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
   end

   // Decode stall: pending load on any named register, or a source operand
   // whose EX result is still buffered or is being written this cycle.
   always_comb begin
      w_haz = r_sb[dec_rs1] || r_sb[dec_rs2] || r_sb[dec_rd];
      if (r_we && ((r_waddr == dec_rs1) || (r_waddr == dec_rs2))) w_haz = 1'b1;
      for (int i = 0; i < SKID_D; i++) begin
         if (w_ent_vld[i] && ((w_ent_rd[i] == dec_rs1) || (w_ent_rd[i] == dec_rs2)))
            w_haz = 1'b1;
      end
   end

   assign hazard   = w_haz;
   assign err      = r_err;
   assign rf_we    = r_we;
   assign rf_waddr = r_waddr;
   assign rf_wdata = r_wdata;

endmodule

// File: tb/tb_wb_sched.sv
// Bench for wb_sched: directed vectors, a queue-based reference model compared
// on every negedge, and literal expectations at the key points.
module tb_wb_sched;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int MAXL = 4;
   localparam int SD   = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_valid;
   logic [AW-1:0] ex_rd;
   logic [DW-1:0] ex_data;
   logic          ex_ready;
   logic          ld_issue;
   logic [AW-1:0] ld_issue_rd;
   logic          ld_can_issue;
   logic          mem_rvalid;
   logic [AW-1:0] mem_rd;
   logic [DW-1:0] mem_rdata;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [AW-1:0] dec_rs1, dec_rs2, dec_rd;
   logic          hazard;
   logic          err;

   int checks = 0;
   int errors = 0;

   wb_sched #(.DATA_W(DW), .RA_W(AW), .MAX_LD(MAXL), .SKID_D(SD)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
      .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_can_issue(ld_can_issue),
      .mem_rvalid(mem_rvalid), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .hazard(hazard), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int                    m_ld;
   bit                    m_sb [32];
   logic [AW+DW-1:0]      m_buf [$];
   bit                    m_we;
   logic [AW-1:0]         m_waddr;
   logic [DW-1:0]         m_wdata;
   bit                    m_err;
   bit                    m_init = 0;

   function automatic bit m_hazard();
      bit h;
      h = m_sb[dec_rs1] || m_sb[dec_rs2] || m_sb[dec_rd];
      if (m_we && (m_waddr == dec_rs1 || m_waddr == dec_rs2)) h = 1;
      foreach (m_buf[i]) begin
         if (m_buf[i][AW+DW-1:DW] == dec_rs1 || m_buf[i][AW+DW-1:DW] == dec_rs2) h = 1;
      end
      return h;
   endfunction

   // Advance the model over the coming posedge using the inputs now applied.
   task automatic model_step();
      int            pre;
      bit            wr;
      bit            iss_ok, rv_ok;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      if (rst) begin
         m_ld = 0;
         foreach (m_sb[i]) m_sb[i] = 0;
         m_buf.delete();
         m_we = 0; m_waddr = '0; m_wdata = '0; m_err = 0;
         m_init = 1;
         return;
      end
      pre = m_buf.size();
      wr  = 0; a = '0; d = '0;
      rv_ok  = mem_rvalid && (m_ld > 0);
      iss_ok = ld_issue && (m_ld < MAXL);
      if (mem_rvalid) begin
         if (m_ld == 0) m_err = 1;
         else begin
            wr = 1; a = mem_rd; d = mem_rdata;
            if (!m_sb[mem_rd]) m_err = 1;
         end
      end else if (pre > 0) begin
         {a, d} = m_buf.pop_front();
         wr = 1;
      end
      if (ex_valid && pre < SD) begin
         if (!mem_rvalid && pre == 0) begin
            wr = 1; a = ex_rd; d = ex_data;
         end else m_buf.push_back({ex_rd, ex_data});
      end
      if (ld_issue && !iss_ok) m_err = 1;
      if (mem_rvalid) m_sb[mem_rd] = 0;
      if (iss_ok) m_sb[ld_issue_rd] = 1;
      m_ld = m_ld + int'(iss_ok) - int'(rv_ok);
      m_we = wr;
      if (wr) begin m_waddr = a; m_wdata = d; end
   endtask

   // Compare DUT against the model at every negedge, then step the model.
   initial begin
      forever begin
         @(negedge clk);
         if (m_init) begin
            chk("m_rf_we", rf_we, m_we);
            if (m_we) begin
               chk("m_rf_waddr", rf_waddr, m_waddr);
               chk("m_rf_wdata", rf_wdata, m_wdata);
            end
            chk("m_ex_ready", ex_ready, m_buf.size() < SD);
            chk("m_ld_can_issue", ld_can_issue, m_ld < MAXL);
            chk("m_hazard", hazard, m_hazard());
            chk("m_err", err, m_err);
         end
         model_step();
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      ex_valid = 0; ex_rd = '0; ex_data = '0;
      ld_issue = 0; ld_issue_rd = '0;
      mem_rvalid = 0; mem_rd = '0; mem_rdata = '0;
      dec_rs1 = 5'd31; dec_rs2 = 5'd31; dec_rd = 5'd31;
      rst = 0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      nxt(); rst = 1;
      nxt();
   endtask

   task automatic ex(input logic [AW-1:0] rd, input logic [DW-1:0] d);
      ex_valid = 1; ex_rd = rd; ex_data = d;
   endtask

   task automatic rv(input logic [AW-1:0] rd, input logic [DW-1:0] d);
      mem_rvalid = 1; mem_rd = rd; mem_rdata = d;
   endtask

   task automatic iss(input logic [AW-1:0] rd);
      ld_issue = 1; ld_issue_rd = rd;
   endtask

   initial begin
      idle(); rst = 1;
      nxt(); rst = 1;
      nxt(); rst = 1;
      @(negedge clk);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_ex_ready", ex_ready, 1);
      chk("rst_ld_can_issue", ld_can_issue, 1);
      chk("rst_hazard", hazard, 0);
      chk("rst_err", err, 0);

      // 1: direct EX write
      nxt(); ex(5'd3, 32'h1234);
      @(negedge clk); chk("t1_ready", ex_ready, 1);
      nxt();
      @(negedge clk);
      chk("t1_we", rf_we, 1); chk("t1_waddr", rf_waddr, 3);
      chk("t1_wdata", rf_wdata, 32'h1234); chk("t1_ready2", ex_ready, 1);

      // 2: single load, hazard lifecycle
      nxt(); iss(5'd5);
      nxt(); dec_rs1 = 5'd5;
      @(negedge clk); chk("t2_haz_pend", hazard, 1);
      nxt(); dec_rs1 = 5'd5;
      nxt(); dec_rs1 = 5'd5; rv(5'd5, 32'hDEADBEEF);
      nxt(); dec_rs1 = 5'd5;
      @(negedge clk);
      chk("t2_we", rf_we, 1); chk("t2_waddr", rf_waddr, 5);
      chk("t2_wdata", rf_wdata, 32'hDEADBEEF);
      nxt(); dec_rs1 = 5'd5;
      @(negedge clk); chk("t2_haz_clear", hazard, 0);

      // 3: loads pre-empt EX, EX buffered and written in order
      do_reset();
      nxt(); iss(5'd9);
      nxt(); iss(5'd10);
      nxt(); iss(5'd11);
      nxt(); rv(5'd9, 32'hA9); ex(5'd1, 32'h11);
      @(negedge clk); chk("t3_c0_ready", ex_ready, 1);
      nxt(); rv(5'd10, 32'hAA); ex(5'd2, 32'h22);
      @(negedge clk); chk("t3_c1_waddr", rf_waddr, 9);
      nxt(); rv(5'd11, 32'hAB); ex(5'd3, 32'h33);
      @(negedge clk); chk("t3_c2_ready", ex_ready, 0); chk("t3_c2_waddr", rf_waddr, 10);
      nxt(); ex(5'd3, 32'h33);
      @(negedge clk); chk("t3_c3_ready", ex_ready, 0); chk("t3_c3_waddr", rf_waddr, 11);
      nxt(); ex(5'd3, 32'h33);
      @(negedge clk); chk("t3_c4_ready", ex_ready, 1);
      chk("t3_c4_waddr", rf_waddr, 1); chk("t3_c4_wdata", rf_wdata, 32'h11);
      nxt();
      @(negedge clk); chk("t3_c5_waddr", rf_waddr, 2); chk("t3_c5_wdata", rf_wdata, 32'h22);
      nxt();
      @(negedge clk); chk("t3_c6_waddr", rf_waddr, 3); chk("t3_c6_wdata", rf_wdata, 32'h33);
      nxt();
      @(negedge clk); chk("t3_c7_we", rf_we, 0);

      // 4: load limit
      do_reset();
      for (int i = 0; i < MAXL; i++) begin
         nxt(); iss(AW'(12 + i));
         @(negedge clk); chk("t4_can_before", ld_can_issue, 1);
      end
      nxt();
      @(negedge clk); chk("t4_full", ld_can_issue, 0);
      nxt(); iss(5'd16);
      nxt(); dec_rs1 = 5'd16;
      @(negedge clk);
      chk("t4_err", err, 1); chk("t4_no_sb16", hazard, 0); chk("t4_still_full", ld_can_issue, 0);
      nxt(); rv(5'd12, 32'hC);
      nxt();
      @(negedge clk); chk("t4_can_after", ld_can_issue, 1);
      nxt(); rv(5'd13, 32'hD);
      nxt(); rv(5'd14, 32'hE);
      nxt(); rv(5'd15, 32'hF);

      // 5: set wins over clear; return with nothing outstanding
      do_reset();
      nxt(); iss(5'd7);
      nxt(); iss(5'd7); rv(5'd7, 32'h77);
      nxt(); dec_rs1 = 5'd7;
      @(negedge clk);
      chk("t5_we", rf_we, 1); chk("t5_waddr", rf_waddr, 7);
      chk("t5_haz", hazard, 1); chk("t5_err0", err, 0);
      nxt(); dec_rs1 = 5'd7;
      @(negedge clk); chk("t5_sb_kept", hazard, 1);
      nxt(); rv(5'd7, 32'h78);
      nxt();
      nxt(); dec_rs1 = 5'd7;
      @(negedge clk); chk("t5_haz_gone", hazard, 0); chk("t5_err_still0", err, 0);
      nxt(); rv(5'd8, 32'h88);
      nxt();
      @(negedge clk); chk("t5_suppressed", rf_we, 0); chk("t5_err1", err, 1);

      // 6: reset discards buffered EX results and pending loads
      do_reset();
      nxt(); iss(5'd20);
      nxt(); iss(5'd21);
      nxt(); iss(5'd22);
      nxt(); rv(5'd20, 32'h20); ex(5'd1, 32'h61);
      nxt(); rv(5'd21, 32'h21); ex(5'd2, 32'h62);
      nxt(); rst = 1;
      nxt(); dec_rs1 = 5'd22; dec_rs2 = 5'd1;
      @(negedge clk);
      chk("t6_we", rf_we, 0); chk("t6_haz", hazard, 0);
      chk("t6_ready", ex_ready, 1); chk("t6_can", ld_can_issue, 1); chk("t6_err", err, 0);
      for (int i = 0; i < 3; i++) begin
         nxt(); iss(AW'(23 + i));
      end
      nxt();
      @(negedge clk); chk("t6_cnt3_can", ld_can_issue, 1); chk("t6_no_stale", rf_we, 0);
      nxt(); iss(5'd26);
      nxt();
      @(negedge clk); chk("t6_cnt4_full", ld_can_issue, 0);
      repeat (3) nxt();

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
